// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the multicycle ALU datapath and its
// sequential multiply/divide unit.
//   * 5-bit operation codes
//   * control FSM state type
//   * helpers for splitting the {HI, LO} result and sizing the iteration
//     accumulator
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // LO occupies result[WIDTH-1:0], HI occupies result[2*WIDTH-1:WIDTH].
    localparam int unsigned RES_LO_LSB = 0;

    function automatic int unsigned res_hi_lsb(input int unsigned width);
        return width;
    endfunction

    // Extra sign/headroom bits on the iteration accumulator: the Booth
    // accumulator must hold +/-2^WIDTH, the non-restoring partial
    // remainder must hold 2*R+1 for |R| up to the divisor magnitude.
    localparam int unsigned ACC_GUARD = 2;

    // Operations that need the iterative unit (DIV by zero is short-cut).
    function automatic logic uses_muldiv(input logic [OP_W-1:0] op,
                                         input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv -- iterative signed multiply / divide, one step per clock.
//   MUL: radix-2 Booth, WIDTH steps, full 2*WIDTH product in {hi, lo}.
//   DIV: non-restoring on operand magnitudes, WIDTH steps; remainder
//        correction and sign fix-up are folded into the final step.
//        lo = quotient (truncated toward zero), hi = remainder (sign of a).
// Ports:
//   clock, clear_n  rising-edge clock, asynchronous active-low reset
//   start           load operands this edge (caller ensures unit is idle)
//   is_div          1 = divide, 0 = multiply (sampled with start)
//   a, b            multiplicand/multiplier or dividend/divisor
//   done            high during the cycle whose closing edge writes hi/lo
//   hi, lo          registered result, held until the next completion
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + ACC_GUARD;

    logic [CW-1:0]    count;
    logic             div_q;
    logic             neg_quo;
    logic             neg_rem;
    logic             q_m1;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    mcand;
    logic [WIDTH-1:0] mq;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [AW-1:0]    booth_sum;
    logic [AW-1:0]    booth_acc;
    logic [WIDTH-1:0] booth_mq;
    logic [AW-1:0]    div_shift;
    logic [AW-1:0]    div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;

    assign done = (count == CW'(1));

    always_comb begin
        // Magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;

        // Booth step: examine {Q0, Q-1}, add/subtract, arithmetic shift right
        // of {acc, mq, q_m1}.
        booth_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[AW-1], booth_sum[AW-1:1]};
        booth_mq  = {booth_sum[0], mq[WIDTH-1:1]};

        // Non-restoring step: shift {R, Q} left, subtract when R >= 0 else add.
        div_shift = {acc[AW-2:0], mq[WIDTH-1]};
        div_rem   = acc[AW-1] ? (div_shift + mcand) : (div_shift - mcand);
        div_quo   = {mq[WIDTH-2:0], ~div_rem[AW-1]};

        // Final correction: a negative remainder gets the divisor added back.
        // The corrected value lies in [0, |b|) so the low WIDTH bits suffice.
        rem_fix = div_rem[AW-1] ? (div_rem[WIDTH-1:0] + mcand[WIDTH-1:0])
                                : div_rem[WIDTH-1:0];
        quo_out = neg_quo ? -div_quo : div_quo;
        rem_out = neg_rem ? -rem_fix : rem_fix;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count   <= '0;
            div_q   <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            q_m1    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mq      <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (start) begin
            count <= CW'(WIDTH);
            div_q <= is_div;
            acc   <= '0;
            q_m1  <= 1'b0;
            if (is_div) begin
                mcand   <= {{ACC_GUARD{1'b0}}, b_mag};
                mq      <= a_mag;
                neg_quo <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem <= a[WIDTH-1];
            end else begin
                mcand   <= {{ACC_GUARD{a[WIDTH-1]}}, a};
                mq      <= b;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (div_q) begin
                acc <= div_rem;
                mq  <= div_quo;
                if (done) begin
                    lo <= quo_out;
                    hi <= rem_out;
                end
            end else begin
                acc  <= booth_acc;
                mq   <= booth_mq;
                q_m1 <= mq[0];
                if (done) begin
                    hi <= booth_acc[WIDTH-1:0];
                    lo <= booth_mq;
                end
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu -- ALU with single-cycle logic/arith/shift ops and
// iterative signed MUL/DIV.
// Ports:
//   clock        sole clock, rising edge
//   clear_n      asynchronous active-low reset
//   start        request, accepted only while busy = 0
//   op[4:0]      operation code (alu_pkg OP_*)
//   a, b         operands, captured on the accept edge
//   busy         operation in progress
//   done         one-cycle pulse: result / div_by_zero are new
//   result       {HI, LO}; single-cycle ops return HI = 0
//   div_by_zero  set with done for DIV with b = 0
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int unsigned HI_LSB = res_hi_lsb(WIDTH);
    localparam int unsigned LO_LSB = RES_LO_LSB;

    state_t           state;
    state_t           state_nx;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             dbz_q;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] alu_lo;
    logic [SHW-1:0]   amt;

    assign accept   = (state == ST_IDLE) && start;
    assign md_start = accept && uses_muldiv(op, b == '0);

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (md_start),
        .is_div  (op == OP_DIV),
        .a       (a),
        .b       (b),
        .done    (md_done),
        .hi      (md_hi),
        .lo      (md_lo)
    );

    // Control FSM: state register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Control FSM: next state and busy
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    case (op)
                        OP_MUL:  state_nx = ST_MUL;
                        OP_DIV:  state_nx = ST_DIV;
                        default: state_nx = ST_DONE;
                    endcase
                end
            end
            ST_MUL: begin
                if (md_done) state_nx = ST_DONE;
            end
            ST_DIV: begin
                // A zero divisor never started the iterative unit.
                if (dbz_q || md_done) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept; later input changes are ignored.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            dbz_q <= (op == OP_DIV) && (b == '0);
        end
    end

    // Single-cycle datapath on captured operands.
    assign amt = b_q[SHW-1:0];

    always_comb begin
        alu_lo = a_q;
        case (op_q)
            OP_ADD:  alu_lo = a_q + b_q;
            OP_SUB:  alu_lo = a_q - b_q;
            OP_AND:  alu_lo = a_q & b_q;
            OP_OR:   alu_lo = a_q | b_q;
            // Rotates shift a doubled copy so amount 0 needs no special case.
            OP_ROR:  alu_lo = WIDTH'({a_q, a_q} >> amt);
            OP_ROL:  alu_lo = WIDTH'(({a_q, a_q} << amt) >> WIDTH);
            OP_SHR:  alu_lo = a_q >> amt;
            OP_SHRA: alu_lo = $signed(a_q) >>> amt;
            OP_SHL:  alu_lo = a_q << amt;
            OP_NEG:  alu_lo = '0 - a_q;
            OP_NOT:  alu_lo = ~a_q;
            default: alu_lo = a_q;
        endcase
    end

    // Result register: written only on the DONE cycle, so it holds between
    // completions and done/busy change on the same edge.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (state == ST_DONE) begin
            done <= 1'b1;
            if (dbz_q) begin
                result[HI_LSB +: WIDTH] <= a_q;
                result[LO_LSB +: WIDTH] <= '1;
                div_by_zero             <= 1'b1;
            end else if ((op_q == OP_MUL) || (op_q == OP_DIV)) begin
                result[HI_LSB +: WIDTH] <= md_hi;
                result[LO_LSB +: WIDTH] <= md_lo;
                div_by_zero             <= 1'b0;
            end else begin
                result[HI_LSB +: WIDTH] <= '0;
                result[LO_LSB +: WIDTH] <= alu_lo;
                div_by_zero             <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu -- randomized and directed stimulus against a
// behavioural model (plain 64-bit arithmetic, accept/latency rule) for
// multicycle_alu with WIDTH = 32.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [2*W-1:0] result;
    logic          div_by_zero;

    multicycle_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          acc_edge;
        int          done_edge;
        logic [63:0] res;
        logic        dbz;
        logic        lit_v;
        logic [63:0] lit;
    } txn_t;

    txn_t        q[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          last_done_edge = -1;
    logic [63:0] hold_res = '0;
    logic        hold_dbz = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference: {div_by_zero, HI, LO}
    function automatic logic [64:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, qq, rr;
        int unsigned n;
        logic [31:0] lo;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        n  = int'(y[4:0]);
        lo = x;
        case (o)
            OP_ADD:  lo = x + y;
            OP_SUB:  lo = x - y;
            OP_AND:  lo = x & y;
            OP_OR:   lo = x | y;
            OP_ROR:  lo = (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            OP_ROL:  lo = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            OP_SHR:  lo = x >> n;
            OP_SHL:  lo = x << n;
            OP_SHRA: begin p = sx >>> n; lo = p[31:0]; end
            OP_NEG:  lo = 32'd0 - x;
            OP_NOT:  lo = ~x;
            OP_MUL:  begin p = sx * sy; return {1'b0, p[63:0]}; end
            OP_DIV: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                qq = sx / sy;
                rr = sx % sy;
                return {1'b0, rr[31:0], qq[31:0]};
            end
            default: lo = x;
        endcase
        return {1'b0, 32'd0, lo};
    endfunction

    function automatic int latency(input logic [4:0] o, input logic [31:0] y);
        if (o == OP_MUL) return W + 1;
        if (o == OP_DIV) return (y == 0) ? 2 : W + 1;
        return 1;
    endfunction

    // Drive one cycle of inputs (called at negedge+1) and predict acceptance
    // on the upcoming edge: idle means the previous op's done edge has passed.
    task automatic drive(input logic s, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic lv, input logic [63:0] lit);
        logic [64:0] m;
        int e;
        start = s; op = o; a = x; b = y;
        e = cyc + 1;
        if (clear_n && s && e > last_done_edge) begin
            m = model(o, x, y);
            q.push_back('{acc_edge: e, done_edge: e + latency(o, y), res: m[63:0],
                          dbz: m[64], lit_v: lv, lit: lit});
            last_done_edge = e + latency(o, y);
        end
        @(negedge clock); #1;
    endtask

    function automatic logic [4:0] rand_op();
        logic [4:0] t [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                               OP_SHRA, OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT};
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 13) return t[r];
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic settle();
        while (cyc + 1 <= last_done_edge)
            drive(1'($urandom_range(0, 1)), rand_op(), rand_val(), rand_val(), 1'b0, 64'd0);
    endtask

    task automatic do_reset(input int n);
        clear_n = 1'b0;
        start = 1'b0;
        q.delete();
        last_done_edge = -1;
        repeat (n) begin @(negedge clock); #1; end
        clear_n = 1'b1;
    endtask

    // Compare process: every cycle, outputs against the model's view.
    always @(negedge clock) begin : mon
        logic eb, ed;
        if (!clear_n) begin
            hold_res = '0;
            hold_dbz = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_dbz", div_by_zero, 0);
        end else begin
            eb = 1'b0;
            ed = 1'b0;
            if (q.size() > 0) begin
                eb = (cyc >= q[0].acc_edge) && (cyc < q[0].done_edge);
                ed = (cyc == q[0].done_edge);
            end
            if (ed) begin
                hold_res = q[0].res;
                hold_dbz = q[0].dbz;
                if (q[0].lit_v) chk("literal", result, q[0].lit);
                void'(q.pop_front());
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("result", result, hold_res);
            chk("div_by_zero", div_by_zero, hold_dbz);
        end
    end

    localparam int NDIR = 14;
    logic [4:0]  d_op  [NDIR] = '{OP_ADD, OP_MUL, OP_MUL, OP_DIV, OP_DIV, OP_SHRA, OP_ROL,
                                  OP_DIV, OP_ROR, OP_SUB, 5'b11111, OP_NEG, OP_SHR, OP_DIV};
    logic [31:0] d_a   [NDIR] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd5,
                                  32'h80000000, 32'h80000001, 32'h80000000, 32'h1, 32'h0,
                                  32'h12345678, 32'h1, 32'h80000000, 32'd7};
    logic [31:0] d_b   [NDIR] = '{32'h1, 32'd7, 32'h80000000, 32'd2, 32'd0, 32'h21, 32'd4,
                                  32'hFFFFFFFF, 32'h1, 32'h1, 32'h9, 32'h0, 32'h1F, 32'hFFFFFFFE};
    logic [63:0] d_exp [NDIR] = '{64'h0, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                                  64'hFFFFFFFF_FFFFFFFD, 64'h00000005_FFFFFFFF, 64'h00000000_C0000000,
                                  64'h00000000_00000018, 64'h00000000_80000000, 64'h00000000_80000000,
                                  64'h00000000_FFFFFFFF, 64'h00000000_12345678, 64'h00000000_FFFFFFFF,
                                  64'h00000000_00000001, 64'h00000001_FFFFFFFD};

    initial begin
        logic [64:0] m;

        // Pin the model against hand-computed values.
        for (int i = 0; i < NDIR; i++) begin
            m = model(d_op[i], d_a[i], d_b[i]);
            chk($sformatf("pin_model_%0d", i), m[63:0], d_exp[i]);
        end
        m = model(OP_DIV, 32'd5, 32'd0);
        chk("pin_model_dbz", m[64], 1);

        repeat (3) @(negedge clock);
        #1;
        clear_n = 1'b1;

        // Directed cases with literal expectations on the DUT result.
        for (int i = 0; i < NDIR; i++) begin
            drive(1'b1, d_op[i], d_a[i], d_b[i], 1'b1, d_exp[i]);
            settle();
        end

        // Reset in the middle of a MUL: no done, then a clean ADD.
        drive(1'b1, OP_MUL, 32'd1234, 32'd5678, 1'b0, 64'd0);
        repeat (9) drive(1'b0, OP_ADD, $urandom, $urandom, 1'b0, 64'd0);
        do_reset(1);
        drive(1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 64'd4);
        settle();

        // start held through DIVs: one done per op, next accept right after.
        repeat (70) drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        settle();

        // start held on single-cycle ops: accept every other edge.
        repeat (8) drive(1'b1, OP_ADD, 32'd40, 32'd2, 1'b1, 64'd42);
        settle();

        // Randomized traffic with occasional resets.
        repeat (2500) begin
            if ($urandom_range(0, 299) == 0)
                do_reset(2);
            else
                drive(($urandom_range(0, 2) == 0), rand_op(), rand_val(), rand_val(), 1'b0, 64'd0);
        end
        settle();
        repeat (3) drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
